// File: rtl/div_sys_mem_stream_loader.sv
// Avalon-ST to on-chip RAM loader: writes a programmed number of stream words to
// consecutive word addresses from BASE, keeps a running checksum and raises a done interrupt.
module div_sys_mem_stream_loader #(
   parameter int unsigned DEPTH  = 30000,
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          csr_address,
   input  logic                csr_read,
   input  logic                csr_write,
   input  logic [31:0]         csr_writedata,
   output logic [31:0]         csr_readdata,
   input  logic [DATA_W-1:0]   snk_data,
   input  logic                snk_valid,
   output logic                snk_ready,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   output logic                irq
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned SUM_W = LEN_W + 1;
   localparam int unsigned BE_W  = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
   logic [LEN_W-1:0]    length_q, length_d, remaining_q, remaining_d, words_q, words_d;
   logic [DATA_W-1:0]   checksum_q, checksum_d;
   logic                irq_en_q, irq_en_d, done_q, done_d;
   logic                range_err_q, range_err_d, aborted_q, aborted_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]     mem_be_q, mem_be_d;
   logic                mem_write_q, mem_write_d, irq_q, irq_d;

   logic                busy, wr_ctrl, go, abort, accept;
   logic [SUM_W-1:0]    end_addr;
   logic                csr_wdata_unused;

   assign csr_wdata_unused = ^csr_writedata[31:LEN_W];

   assign busy     = (state_q != S_IDLE);
   assign wr_ctrl  = csr_write && (csr_address == 3'd2);
   assign go       = wr_ctrl && csr_writedata[0];
   assign abort    = wr_ctrl && csr_writedata[2];
   assign end_addr = SUM_W'(base_q) + SUM_W'(length_q);
   assign accept   = snk_ready && snk_valid;

   // Next-state, CSR update and write-issue logic
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      length_d    = length_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      words_d     = words_q;
      checksum_d  = checksum_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      range_err_d = range_err_q;
      aborted_d   = aborted_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = '0;
      mem_write_d = 1'b0;
      rdata_d     = '0;
      snk_ready   = (state_q == S_RUN) && (remaining_q != '0) && !abort;

      if (csr_write && !busy && (csr_address == 3'd0)) base_d   = csr_writedata[ADDR_W-1:0];
      if (csr_write && !busy && (csr_address == 3'd1)) length_d = csr_writedata[LEN_W-1:0];
      if (wr_ctrl) irq_en_d = csr_writedata[1];
      // W1C clears first so a same-cycle hardware set below takes priority
      if (csr_write && (csr_address == 3'd3)) begin
         done_d      = done_q      & ~csr_writedata[1];
         range_err_d = range_err_q & ~csr_writedata[2];
         aborted_d   = aborted_q   & ~csr_writedata[3];
      end

      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (end_addr > SUM_W'(DEPTH)) begin
                  range_err_d = 1'b1;
               end else if (length_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d      = base_q;
                  remaining_d = length_q;
                  checksum_d  = '0;
                  words_d     = '0;
                  state_d     = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (accept) begin
               mem_write_d = 1'b1;
               mem_be_d    = '1;
               mem_addr_d  = addr_q;
               mem_wdata_d = snk_data;
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
               checksum_d  = checksum_q + snk_data;
               words_d     = words_q + LEN_W'(1);
               if (remaining_q == LEN_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      irq_d = done_d && irq_en_d;

      if (csr_read) begin
         case (csr_address)
            3'd0:    rdata_d = 32'(base_q);
            3'd1:    rdata_d = 32'(length_q);
            3'd3:    rdata_d = 32'({aborted_q, range_err_q, done_q, busy});
            3'd4:    rdata_d = 32'(checksum_q);
            3'd5:    rdata_d = 32'(words_q);
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         length_q    <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         words_q     <= '0;
         checksum_q  <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
         aborted_q   <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         mem_write_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         length_q    <= length_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         words_q     <= words_d;
         checksum_q  <= checksum_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         range_err_q <= range_err_d;
         aborted_q   <= aborted_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_write_q <= mem_write_d;
         irq_q       <= irq_d;
      end
   end

   assign csr_readdata   = rdata_q;
   assign mem_address    = mem_addr_q;
   assign mem_writedata  = mem_wdata_q;
   assign mem_byteenable = mem_be_q;
   assign mem_write      = mem_write_q;
   assign mem_chipselect = mem_write_q;
   assign mem_clken      = 1'b1;
   assign irq            = irq_q;

endmodule

// File: tb/tb_div_sys_mem_stream_loader.sv
// Directed bench for the stream-to-RAM loader: table of transfers plus abort,
// busy-GO and mid-transfer reset sequences.
module tb_div_sys_mem_stream_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  csr_address = '0;
   logic        csr_read = 1'b0, csr_write = 1'b0;
   logic [31:0] csr_writedata = '0, csr_readdata;
   logic [31:0] snk_data = '0;
   logic        snk_valid = 1'b0, snk_ready;
   logic [14:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken, irq;
   logic [31:0] mem_writedata;

   div_sys_mem_stream_loader dut (
      .clk(clk), .reset_n(reset_n),
      .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .irq(irq)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0, total_cnt = 0, cyc = 0;
   always @(posedge clk) cyc++;

   // Write monitor: every accepted word must appear as exactly one write on the next cycle
   logic        prev_acc = 1'b0;
   logic [31:0] prev_data = '0;
   int          lat_err = 0;
   logic [14:0] wq_addr[$];
   logic [31:0] wq_data[$];
   int          wq_cyc[$];
   always @(negedge clk) begin
      if (!reset_n) prev_acc = 1'b0;
      else begin
         if (mem_write !== prev_acc) lat_err++;
         if (mem_chipselect !== mem_write) lat_err++;
         if (mem_write === 1'b1) begin
            if (mem_byteenable !== 4'hF || mem_writedata !== prev_data) lat_err++;
            wq_addr.push_back(mem_address);
            wq_data.push_back(mem_writedata);
            wq_cyc.push_back(cyc);
         end
         prev_acc  = snk_valid & snk_ready;
         prev_data = snk_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
      csr_address = a; csr_writedata = d; csr_write = 1'b1;
      @(posedge clk); #1;
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
      csr_address = a; csr_read = 1'b1;
      @(posedge clk); #1;
      csr_read = 1'b0;
      d = csr_readdata;
   endtask

   task automatic send_stream(input logic [31:0] d0, input logic [31:0] step, input int n,
                              input bit gap, output logic [31:0] sum);
      logic [31:0] w;
      logic        ok;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         w = d0 + step * 32'(i);
         snk_data = w; snk_valid = 1'b1; ok = 1'b0;
         for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); ok = snk_ready;
            @(posedge clk); #1;
         end
         if (!ok) begin
            chk("stream_accept_timeout", {31'b0, ok}, 32'd1);
            snk_valid = 1'b0;
            return;
         end
         sum = sum + w;
         if (gap) begin
            snk_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      snk_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      for (int t = 0; t < 100; t++) begin
         csr_rd(3'd3, s);
         if (!s[0]) return;
      end
      chk("wait_idle_timeout", s, 32'd0);
   endtask

   task automatic check_writes(input string nm, input int idx0, input logic [14:0] base,
                               input int n, input logic [31:0] d0, input logic [31:0] step,
                               input bit consec);
      chk({nm, "_nwrites"}, 32'(wq_addr.size() - idx0), 32'(n));
      for (int i = 0; i < n && idx0 + i < wq_addr.size(); i++) begin
         chk($sformatf("%s_addr%0d", nm, i), 32'(wq_addr[idx0+i]), 32'(base + 15'(i)));
         chk($sformatf("%s_data%0d", nm, i), wq_data[idx0+i], d0 + step * 32'(i));
         if (consec && i > 0)
            chk($sformatf("%s_cyc%0d", nm, i), 32'(wq_cyc[idx0+i] - wq_cyc[idx0+i-1]), 32'd1);
      end
   endtask

   typedef struct {
      logic [14:0] base;
      logic [15:0] len;
      bit          gap;
      bit          irq_en;
      logic [31:0] d0;
      logic [31:0] step;
      logic [3:0]  exp_status;
      logic [31:0] exp_cksum;
      logic [15:0] exp_words;
      int          exp_nwr;
   } vec_t;

   vec_t vt[5];

   initial begin
      logic [31:0] s, sum, s1, s2;
      int idx0, err0;

      vt[0] = '{15'h100, 16'd4, 1'b0, 1'b0, 32'h11, 32'h11, 4'b0010, 32'hAA, 16'd4, 4};
      vt[1] = '{15'h100, 16'd4, 1'b1, 1'b1, 32'h11, 32'h11, 4'b0010, 32'hAA, 16'd4, 4};
      vt[2] = '{15'd29998, 16'd3, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100, 32'hAA, 16'd4, 0};
      vt[3] = '{15'd29998, 16'd2, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0001, 4'b0010,
                32'h8000_0001, 16'd2, 2};
      vt[4] = '{15'd5, 16'd0, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0010, 32'h8000_0001, 16'd2, 0};

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
      chk("rst_mem_clken", {31'b0, mem_clken}, 32'd1);
      chk("rst_snk_ready", {31'b0, snk_ready}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_readdata", csr_readdata, 32'd0);
      csr_rd(3'd3, s); chk("rst_status", s, 32'd0);

      for (int v = 0; v < 5; v++) begin
         idx0 = wq_addr.size(); err0 = lat_err;
         csr_wr(3'd0, 32'(vt[v].base));
         csr_wr(3'd1, 32'(vt[v].len));
         csr_wr(3'd2, {30'b0, vt[v].irq_en, 1'b1});
         chk($sformatf("v%0d_ready_after_go", v), {31'b0, snk_ready}, 32'(vt[v].exp_nwr > 0));
         if (vt[v].len == 16'd0) begin
            csr_rd(3'd3, s); chk($sformatf("v%0d_done_next_cycle", v), s, 32'd2);
         end
         if (vt[v].exp_nwr > 0) send_stream(vt[v].d0, vt[v].step, vt[v].exp_nwr, vt[v].gap, sum);
         wait_idle();
         repeat (2) @(posedge clk); #1;
         csr_rd(3'd3, s); chk($sformatf("v%0d_status", v), s, 32'(vt[v].exp_status));
         csr_rd(3'd4, s); chk($sformatf("v%0d_checksum", v), s, vt[v].exp_cksum);
         csr_rd(3'd5, s); chk($sformatf("v%0d_words", v), s, 32'(vt[v].exp_words));
         chk($sformatf("v%0d_irq", v), {31'b0, irq}, 32'(vt[v].irq_en & vt[v].exp_status[1]));
         check_writes($sformatf("v%0d", v), idx0, vt[v].base, vt[v].exp_nwr,
                      vt[v].d0, vt[v].step, !vt[v].gap);
         csr_wr(3'd3, 32'hE);
         chk($sformatf("v%0d_irq_after_w1c", v), {31'b0, irq}, 32'd0);
         csr_rd(3'd3, s); chk($sformatf("v%0d_status_after_w1c", v), s, 32'd0);
         chk($sformatf("v%0d_write_timing", v), 32'(lat_err), 32'(err0));
      end

      // Abort after three accepted words; the word offered in the abort cycle is refused
      idx0 = wq_addr.size(); err0 = lat_err;
      csr_wr(3'd0, 32'h200); csr_wr(3'd1, 32'd10); csr_wr(3'd2, 32'h1);
      send_stream(32'h1, 32'h1, 3, 1'b0, sum);
      snk_data = 32'h4; snk_valid = 1'b1;
      csr_address = 3'd2; csr_writedata = 32'h4; csr_write = 1'b1;
      @(negedge clk); chk("abort_ready_low", {31'b0, snk_ready}, 32'd0);
      @(posedge clk); #1;
      csr_write = 1'b0; snk_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      csr_rd(3'd3, s); chk("abort_status", s, 32'h8);
      csr_rd(3'd5, s); chk("abort_words", s, 32'd3);
      csr_rd(3'd4, s); chk("abort_checksum", s, sum);
      check_writes("abort", idx0, 15'h200, 3, 32'h1, 32'h1, 1'b1);
      chk("abort_write_timing", 32'(lat_err), 32'(err0));
      csr_wr(3'd3, 32'hE);

      // Rerun with GO, BASE and LENGTH writes issued while busy
      idx0 = wq_addr.size(); err0 = lat_err;
      csr_wr(3'd2, 32'h1);
      send_stream(32'h10, 32'h1, 1, 1'b0, s1);
      csr_wr(3'd2, 32'h1);
      csr_wr(3'd0, 32'h7);
      csr_wr(3'd1, 32'd3);
      send_stream(32'h11, 32'h1, 9, 1'b0, s2);
      wait_idle();
      csr_rd(3'd3, s); chk("busy_go_status", s, 32'h2);
      csr_rd(3'd5, s); chk("busy_go_words", s, 32'd10);
      csr_rd(3'd4, s); chk("busy_go_checksum", s, 32'hCD);
      csr_rd(3'd0, s); chk("busy_base_kept", s, 32'h200);
      csr_rd(3'd1, s); chk("busy_len_kept", s, 32'd10);
      check_writes("busy_go", idx0, 15'h200, 10, 32'h10, 32'h1, 1'b0);
      chk("busy_go_write_timing", 32'(lat_err), 32'(err0));
      csr_wr(3'd3, 32'hE);

      // Asynchronous reset while a write is in flight
      csr_wr(3'd0, 32'h300); csr_wr(3'd1, 32'd8); csr_wr(3'd2, 32'h3);
      send_stream(32'h55, 32'h1, 2, 1'b0, sum);
      chk("rst_write_in_flight", {31'b0, mem_write}, 32'd1);
      snk_data = 32'h99; snk_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_mem_write", {31'b0, mem_write}, 32'd0);
      chk("rst_async_chipselect", {31'b0, mem_chipselect}, 32'd0);
      chk("rst_async_snk_ready", {31'b0, snk_ready}, 32'd0);
      snk_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      for (int a = 0; a < 8; a++) begin
         csr_rd(3'(a), s);
         chk($sformatf("post_rst_csr%0d", a), s, 32'd0);
      end
      chk("post_rst_irq", {31'b0, irq}, 32'd0);
      chk("post_rst_mem_address", 32'(mem_address), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_sys_mem_stream_loader.md
Name: div_sys_mem_stream_loader

Overview:
- Stream-to-memory loader that sits directly upstream of the 30000x32 single-port on-chip RAM and drives its s2 slave port.
- Accepts 32-bit words on an Avalon-ST sink and writes them to consecutive word addresses starting at a programmed base.
- Programmed via a small Avalon-MM CSR slave. Raises an interrupt on completion. Keeps a running 32-bit checksum for software verification.

Parameters:
- DEPTH, 30000, memory depth in words; upper bound for range checking.
- ADDR_W, 15, memory word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- csr_address  in  3  CSR word address
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, valid 1 cycle after csr_read
- snk_data  in  32  stream word
- snk_valid  in  1  stream word valid
- snk_ready  out  1  loader can accept a word this cycle
- mem_address  out  15  RAM word address
- mem_byteenable  out  4  always 4'hF during a write
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable, tied 1
- irq  out  1  level interrupt, = done & irq_en

Behaviour:
- Reset: all outputs 0 except mem_clken=1. BASE, LENGTH, CHECKSUM, remaining count and all status bits are 0. FSM goes to IDLE.
- CSR map:
  - 0 BASE[14:0] RW
  - 1 LENGTH[15:0] RW, in words
  - 2 CONTROL (write-only): bit0 GO, bit1 IRQ_EN (sticky), bit2 ABORT
  - 3 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 RANGE_ERR (W1C), bit3 ABORTED (W1C)
  - 4 CHECKSUM RO
  - 5 WORDS_WRITTEN[15:0] RO
  - unmapped reads return 0; csr_readdata is registered.
- The RAM has no waitrequest; every write completes in the cycle mem_write is high.
- FSM IDLE:
  - On GO, compute BASE+LENGTH in 17 bits.
  - If the sum > DEPTH: set RANGE_ERR, stay IDLE, issue no writes.
  - If LENGTH==0: set DONE next cycle, no writes.
  - Otherwise: load addr=BASE, remaining=LENGTH, clear CHECKSUM and WORDS_WRITTEN, go to RUN.
- FSM RUN:
  - snk_ready = 1 while remaining != 0.
  - On snk_valid & snk_ready: the next cycle drives mem_chipselect=mem_write=1, mem_address=addr, mem_writedata=snk_data. Accept-to-write latency is exactly 1 cycle. Back-to-back acceptance gives one write per cycle.
  - With each accepted word: addr+1, remaining-1, CHECKSUM += data (mod 2^32), WORDS_WRITTEN+1.
  - When the last word is accepted, snk_ready drops the following cycle and the FSM goes to DRAIN.
- FSM DRAIN: the final write issues; DONE is set the same cycle; go to IDLE.
- Address never wraps: range is prechecked, so addr max is DEPTH-1.
- GO while BUSY is ignored. BASE/LENGTH writes while BUSY are ignored.
- ABORT in RUN: stop accepting that cycle (snk_ready=0 in the ABORT cycle), let any pending write issue, set ABORTED (not DONE), return to IDLE. ABORT in IDLE is a no-op.
- If a hardware set and a W1C clear hit the same status bit in the same cycle, set wins.
- GO and ABORT in the same write: ABORT wins if BUSY; GO applies if IDLE.
- Async reset mid-transfer: all activity stops immediately; any write in flight is dropped (mem_write=0).

Test Plan:
- BASE=0x100, LENGTH=4, GO, stream 0x11,0x22,0x33,0x44 back-to-back -> writes to 0x100..0x103 on four consecutive cycles, each 1 cycle after accept; DONE=1; CHECKSUM=0xAA; WORDS_WRITTEN=4.
- Same transfer with snk_valid toggling every other cycle and IRQ_EN=1 -> same memory contents; irq rises on DONE; W1C to STATUS bit1 drops irq.
- BASE=29998, LENGTH=3, GO -> RANGE_ERR=1, BUSY never set, no mem_write. Repeat with LENGTH=2 -> writes at 29998 and 29999, DONE=1.
- LENGTH=0, GO -> DONE=1 next cycle, no writes, snk_ready stays 0.
- LENGTH=10, ABORT after 3 accepts -> exactly 3 writes, ABORTED=1, DONE=0, WORDS_WRITTEN=3, BUSY=0; a second GO while BUSY in a rerun is ignored.
- Drive reset_n low mid-RUN, asynchronous to clk -> mem_write and snk_ready go 0 immediately; all CSRs read 0 after release.
